// File: rtl/register_file.sv
// Architectural register bank: 8 x DATA_WIDTH registers (R0 reads as zero) plus a Zero status flag.
// Reads are combinational; writes take effect on the rising edge; there is no stall, every write is accepted.
module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] ReadReg1,
  input  logic [ADDR_WIDTH-1:0] ReadReg2,
  output logic [DATA_WIDTH-1:0] ReadData1,
  output logic [DATA_WIDTH-1:0] ReadData2,
  input  logic                  RegWrite,
  input  logic [ADDR_WIDTH-1:0] WriteReg,
  input  logic [DATA_WIDTH-1:0] WriteData,
  input  logic                  FlagWrite,
  input  logic                  ZeroIn,
  output logic                  ZeroFlag
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  // R0 has no storage; only R1..R(NUM_REGS-1) are real flops.
  logic [DATA_WIDTH-1:0] regs [1:NUM_REGS-1];

  // Per-register decode: an unknown WriteReg compares as X and leaves every register untouched.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 1; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
      ZeroFlag <= 1'b0;
    end else begin
      for (int i = 1; i < NUM_REGS; i++) begin
        if (RegWrite && (WriteReg == ADDR_WIDTH'(i))) begin
          regs[i] <= WriteData;
        end
      end
      if (FlagWrite) begin
        ZeroFlag <= ZeroIn;
      end
    end
  end

  // No write-to-read bypass: operands are consumed before the edge in a single-cycle datapath.
  always_comb begin
    ReadData1 = '0;
    ReadData2 = '0;
    for (int i = 1; i < NUM_REGS; i++) begin
      if (ReadReg1 == ADDR_WIDTH'(i)) begin
        ReadData1 = regs[i];
      end
      if (ReadReg2 == ADDR_WIDTH'(i)) begin
        ReadData2 = regs[i];
      end
    end
  end

endmodule

// File: tb/tb_register_file.sv
// Self-checking bench for register_file: scoreboard queue of expected read/flag values.
module tb_register_file;

  logic        clk;
  logic        rst_n;
  logic [2:0]  ReadReg1;
  logic [2:0]  ReadReg2;
  logic [15:0] ReadData1;
  logic [15:0] ReadData2;
  logic        RegWrite;
  logic [2:0]  WriteReg;
  logic [15:0] WriteData;
  logic        FlagWrite;
  logic        ZeroIn;
  logic        ZeroFlag;

  typedef struct {
    logic [15:0] d1;
    logic [15:0] d2;
    logic        zf;
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] mdl [8];
  logic        mdl_flag;
  int          checks;
  int          failures;

  register_file #(.DATA_WIDTH(16), .ADDR_WIDTH(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ReadReg1  (ReadReg1),
    .ReadReg2  (ReadReg2),
    .ReadData1 (ReadData1),
    .ReadData2 (ReadData2),
    .RegWrite  (RegWrite),
    .WriteReg  (WriteReg),
    .WriteData (WriteData),
    .FlagWrite (FlagWrite),
    .ZeroIn    (ZeroIn),
    .ZeroFlag  (ZeroFlag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [15:0] mdl_rd(input logic [2:0] a);
    return (a == 3'd0) ? 16'h0000 : mdl[a];
  endfunction

  // Advance one rising edge, updating the reference model from the driven inputs.
  task automatic do_edge();
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
      mdl_flag = 1'b0;
    end else begin
      if (RegWrite && WriteReg != 3'd0) mdl[WriteReg] = WriteData;
      if (FlagWrite) mdl_flag = ZeroIn;
    end
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [15:0] d);
    RegWrite = 1'b1; WriteReg = a; WriteData = d;
    do_edge();
    RegWrite = 1'b0;
  endtask

  task automatic test_reset();
    exp_t e;
    rst_n = 1'b0; RegWrite = 1'b0; FlagWrite = 1'b0; ZeroIn = 1'b0;
    WriteReg = 3'd0; WriteData = 16'h0000; ReadReg1 = 3'd0; ReadReg2 = 3'd0;
    do_edge();
    rst_n = 1'b1;
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a); ReadReg2 = 3'(7 - a);
      exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL reset_init_rd1 a=%0d got=%h exp=%h", a, ReadData1, e.d1); end
      checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL reset_init_rd2 a=%0d got=%h exp=%h", a, ReadData2, e.d2); end
    end
    checks++; if (ZeroFlag !== 1'b0) begin failures++; $display("FAIL reset_init_zf got=%b exp=0", ZeroFlag); end
    for (int a = 1; a < 8; a++) write_reg(3'(a), 16'(a * 16'h1111));
    FlagWrite = 1'b1; ZeroIn = 1'b1; do_edge(); FlagWrite = 1'b0; ZeroIn = 1'b0;
    ReadReg1 = 3'd3; ReadReg2 = 3'd7; #1;
    checks++; if (ReadData1 !== 16'h3333 || ZeroFlag !== 1'b1) begin failures++; $display("FAIL reset_preload got=%h/%b exp=3333/1", ReadData1, ZeroFlag); end
    rst_n = 1'b0; RegWrite = 1'b1; WriteReg = 3'd3; WriteData = 16'hBEEF; FlagWrite = 1'b1; ZeroIn = 1'b1;
    do_edge();
    rst_n = 1'b1; RegWrite = 1'b0; FlagWrite = 1'b0; ZeroIn = 1'b0;
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a); ReadReg2 = 3'(a);
      exp_q.push_back('{16'h0000, 16'h0000, 1'b0});
      #1;
      e = exp_q.pop_front();
      checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL reset_clear_rd1 a=%0d got=%h exp=%h", a, ReadData1, e.d1); end
      checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL reset_clear_rd2 a=%0d got=%h exp=%h", a, ReadData2, e.d2); end
      checks++; if (ZeroFlag !== e.zf) begin failures++; $display("FAIL reset_clear_zf got=%b exp=%b", ZeroFlag, e.zf); end
    end
  endtask

  task automatic test_write_read();
    exp_t e;
    ReadReg1 = 3'd5; ReadReg2 = 3'd5;
    RegWrite = 1'b1; WriteReg = 3'd5; WriteData = 16'hA5A5;
    exp_q.push_back('{16'h0000, 16'h0000, mdl_flag});
    #1;
    e = exp_q.pop_front();
    checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL rdw_old_rd1 got=%h exp=%h", ReadData1, e.d1); end
    checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL rdw_old_rd2 got=%h exp=%h", ReadData2, e.d2); end
    exp_q.push_back('{16'hA5A5, 16'hA5A5, mdl_flag});
    do_edge();
    RegWrite = 1'b0;
    e = exp_q.pop_front();
    checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL wr_rd1 got=%h exp=%h", ReadData1, e.d1); end
    checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL wr_rd2 got=%h exp=%h", ReadData2, e.d2); end
  endtask

  task automatic test_r0_guard();
    exp_t e;
    for (int a = 1; a < 8; a++) write_reg(3'(a), 16'(a * 16'h0101 + 16'h1000));
    write_reg(3'd0, 16'hFFFF);
    for (int a = 0; a < 8; a++) begin
      ReadReg1 = 3'(a); ReadReg2 = 3'(a);
      e.d1 = (a == 0) ? 16'h0000 : 16'(a * 16'h0101 + 16'h1000);
      e.d2 = e.d1; e.zf = mdl_flag;
      exp_q.push_back(e);
      #1;
      e = exp_q.pop_front();
      checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL r0_guard_rd1 a=%0d got=%h exp=%h", a, ReadData1, e.d1); end
      checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL r0_guard_rd2 a=%0d got=%h exp=%h", a, ReadData2, e.d2); end
    end
  endtask

  task automatic test_enable_gating();
    write_reg(3'd2, 16'h0000);
    FlagWrite = 1'b1; ZeroIn = 1'b0; do_edge(); FlagWrite = 1'b0;
    ReadReg1 = 3'd2; ReadReg2 = 3'd6;
    RegWrite = 1'b0; WriteReg = 3'd2; WriteData = 16'h1234;
    for (int c = 0; c < 3; c++) begin
      exp_q.push_back('{16'h0000, 16'h1606, 1'b0});
      do_edge();
      begin
        exp_t e = exp_q.pop_front();
        checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL gate_r2 cyc=%0d got=%h exp=%h", c, ReadData1, e.d1); end
        checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL gate_r6 cyc=%0d got=%h exp=%h", c, ReadData2, e.d2); end
      end
    end
    FlagWrite = 1'b0; ZeroIn = 1'b1;
    for (int c = 0; c < 2; c++) begin
      do_edge();
      checks++; if (ZeroFlag !== 1'b0) begin failures++; $display("FAIL gate_flag cyc=%0d got=%b exp=0", c, ZeroFlag); end
    end
    ZeroIn = 1'b0;
  endtask

  task automatic test_simultaneous();
    exp_t e;
    ReadReg1 = 3'd7; ReadReg2 = 3'd5;
    RegWrite = 1'b1; WriteReg = 3'd7; WriteData = 16'h8000; FlagWrite = 1'b1; ZeroIn = 1'b1;
    exp_q.push_back('{16'h8000, 16'h1505, 1'b1});
    do_edge();
    e = exp_q.pop_front();
    checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL simul_r7 got=%h exp=%h", ReadData1, e.d1); end
    checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL simul_r5 got=%h exp=%h", ReadData2, e.d2); end
    checks++; if (ZeroFlag !== e.zf) begin failures++; $display("FAIL simul_zf got=%b exp=%b", ZeroFlag, e.zf); end
    RegWrite = 1'b0; FlagWrite = 1'b1; ZeroIn = 1'b0;
    exp_q.push_back('{16'h8000, 16'h1505, 1'b0});
    do_edge();
    FlagWrite = 1'b0;
    e = exp_q.pop_front();
    checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL simul_r7_hold got=%h exp=%h", ReadData1, e.d1); end
    checks++; if (ZeroFlag !== e.zf) begin failures++; $display("FAIL simul_zf_clear got=%b exp=%b", ZeroFlag, e.zf); end
  endtask

  task automatic test_alu_loop();
    logic [15:0] diff;
    exp_t e;
    write_reg(3'd4, 16'h4444);
    write_reg(3'd1, 16'h0003);
    write_reg(3'd2, 16'h0003);
    ReadReg1 = 3'd1; ReadReg2 = 3'd2; #1;
    diff = ReadData1 - ReadData2;
    RegWrite = 1'b1; WriteReg = 3'd4; WriteData = diff; FlagWrite = 1'b1; ZeroIn = (diff == 16'h0000);
    exp_q.push_back('{16'h0000, 16'h0003, 1'b1});
    do_edge();
    RegWrite = 1'b0; FlagWrite = 1'b0; ZeroIn = 1'b0;
    ReadReg1 = 3'd4; #1;
    e = exp_q.pop_front();
    checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL alu_r4 got=%h exp=%h", ReadData1, e.d1); end
    checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL alu_r2 got=%h exp=%h", ReadData2, e.d2); end
    checks++; if (ZeroFlag !== e.zf) begin failures++; $display("FAIL alu_zf got=%b exp=%b", ZeroFlag, e.zf); end
  endtask

  task automatic test_back_to_back();
    exp_t e;
    for (int c = 0; c < 40; c++) begin
      RegWrite  = 1'($urandom_range(0, 3) != 0);
      WriteReg  = 3'($urandom_range(0, 7));
      WriteData = 16'($urandom);
      FlagWrite = 1'($urandom_range(0, 1));
      ZeroIn    = 1'($urandom_range(0, 1));
      ReadReg1  = 3'($urandom_range(0, 7));
      ReadReg2  = (c % 4 == 0) ? WriteReg : 3'($urandom_range(0, 7));
      exp_q.push_back('{mdl_rd(ReadReg1), mdl_rd(ReadReg2), mdl_flag});
      #1;
      e = exp_q.pop_front();
      checks++; if (ReadData1 !== e.d1) begin failures++; $display("FAIL b2b_rd1 cyc=%0d got=%h exp=%h", c, ReadData1, e.d1); end
      checks++; if (ReadData2 !== e.d2) begin failures++; $display("FAIL b2b_rd2 cyc=%0d got=%h exp=%h", c, ReadData2, e.d2); end
      checks++; if (ZeroFlag !== e.zf) begin failures++; $display("FAIL b2b_zf cyc=%0d got=%b exp=%b", c, ZeroFlag, e.zf); end
      do_edge();
    end
    RegWrite = 1'b0; FlagWrite = 1'b0;
  endtask

  task automatic test_reset_glitch();
    write_reg(3'd6, 16'hC0DE);
    FlagWrite = 1'b1; ZeroIn = 1'b1; do_edge(); FlagWrite = 1'b0; ZeroIn = 1'b0;
    ReadReg1 = 3'd6; ReadReg2 = 3'd6;
    rst_n = 1'b0; #2; rst_n = 1'b1;
    do_edge();
    checks++; if (ReadData1 !== 16'hC0DE) begin failures++; $display("FAIL glitch_r6 got=%h exp=c0de", ReadData1); end
    checks++; if (ZeroFlag !== 1'b1) begin failures++; $display("FAIL glitch_zf got=%b exp=1", ZeroFlag); end
    rst_n = 1'b0; do_edge(); rst_n = 1'b1;
    checks++; if (ReadData2 !== 16'h0000 || ZeroFlag !== 1'b0) begin failures++; $display("FAIL late_reset got=%h/%b exp=0000/0", ReadData2, ZeroFlag); end
  endtask

  initial begin
    checks = 0; failures = 0; mdl_flag = 1'b0;
    for (int i = 0; i < 8; i++) mdl[i] = 16'h0000;
    test_reset();
    test_write_read();
    test_r0_guard();
    test_enable_gating();
    test_simultaneous();
    test_alu_loop();
    test_back_to_back();
    test_reset_glitch();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
